// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared encodings and constants for the frequency-measurement sequencer.
package freq_meas_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RST_WR, S_START_WR, S_GATE, S_READ, S_DONE, S_ERROR
  } seq_state_t;
  typedef enum logic [1:0] {M_IDLE, M_BUS, M_RTY} bus_state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_RETRY   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [31:0] CTRL_CMD_RST    = 32'h01;
  localparam logic [31:0] CTRL_CMD_START  = 32'h80;
  localparam logic [31:0] DEF_CTRL_ADDR   = 32'h8;
  localparam logic [31:0] DEF_RESULT_ADDR = 32'h9;
  function automatic logic is_bus_state(input seq_state_t s);
    return s inside {S_RST_WR, S_START_WR, S_READ};
  endfunction
endpackage

// File: rtl/freq_wb_master_if.sv
// freq_wb_master_if: single-transaction Wishbone master with retry and timeout handling.
module freq_wb_master_if
  import freq_meas_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic        done,
  output logic [1:0]  err_kind,
  output logic [31:0] rdata
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  bus_state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;
  logic t_err, t_ack, t_rty, rty_over, tout;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= M_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      M_IDLE:  state_nx = req ? M_BUS : M_IDLE;
      M_BUS:   state_nx = done ? M_IDLE : t_rty ? M_RTY : M_BUS;
      M_RTY:   state_nx = M_BUS;
      default: state_nx = M_IDLE;
    endcase
  end
  // Terminations are qualified by stb; err beats ack beats rty.
  always_comb begin
    m_cyc_o  = state != M_IDLE;
    m_stb_o  = state == M_BUS;
    m_sel_o  = 4'hF;
    t_err    = m_stb_o & m_err_i;
    t_ack    = m_stb_o & m_ack_i & ~m_err_i;
    t_rty    = m_stb_o & m_rty_i & ~m_err_i & ~m_ack_i;
    rty_over = t_rty & (rcnt == RW'(MAX_RETRY));
    tout     = m_stb_o & ~m_err_i & ~m_ack_i & ~m_rty_i & (tcnt == TW'(TIMEOUT_CYC - 1));
    done     = t_err | t_ack | rty_over | tout;
    err_kind = t_err ? ERR_BUS : t_ack ? ERR_NONE : rty_over ? ERR_RETRY : tout ? ERR_TIMEOUT : ERR_NONE;
    rdata    = m_dat_i;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      tcnt    <= '0;
      rcnt    <= '0;
    end else begin
      if (state == M_IDLE && req) begin
        m_adr_o <= adr;
        m_dat_o <= wdat;
        m_we_o  <= we;
      end
      tcnt <= state == M_BUS ? tcnt + TW'(1) : '0;
      rcnt <= state == M_IDLE ? '0 : (t_rty && !rty_over) ? rcnt + RW'(1) : rcnt;
    end
endmodule

// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: autonomous Wishbone master running reset/start/gate/read cycles on a frequency counter.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
  parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
  parameter int          GATE_W      = 24,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic              abort_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  output logic              busy_o,
  output logic [31:0]       result_o,
  output logic              result_valid_o,
  output logic [15:0]       meas_count_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [31:0]       m_adr_o,
  output logic [31:0]       m_dat_o,
  input  logic [31:0]       m_dat_i,
  output logic              m_we_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic [3:0]        m_sel_o,
  input  logic              m_ack_i,
  input  logic              m_err_i,
  input  logic              m_rty_i
);
  seq_state_t state, state_nx, tgt, bus_nx;
  logic issued, accept, req, done, bus_we;
  logic [1:0] err_kind;
  logic [31:0] rdata, bus_adr, bus_dat;
  logic [GATE_W-1:0] gate_len, gcnt;
  // A start from IDLE/ERROR issues the first write immediately; later bus states
  // issue on entry, which leaves the mandatory idle cycle after the previous termination.
  always_comb begin
    accept  = start_i & (state == S_IDLE || state == S_ERROR);
    req     = accept | (is_bus_state(state) & ~issued & ~abort_i);
    tgt     = is_bus_state(state) ? state : S_RST_WR;
    bus_we  = tgt != S_READ;
    bus_adr = tgt == S_READ ? RESULT_ADDR : CTRL_ADDR;
    bus_dat = tgt == S_RST_WR ? CTRL_CMD_RST : tgt == S_START_WR ? CTRL_CMD_START : 32'h0;
    bus_nx  = state == S_RST_WR ? S_START_WR : state == S_START_WR ? S_GATE : S_DONE;
  end
  freq_wb_master_if #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) u_bus (
    .clk_i(clk_i), .rst_i(rst_i), .req(req), .we(bus_we), .adr(bus_adr), .wdat(bus_dat),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_sel_o(m_sel_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .done(done), .err_kind(err_kind), .rdata(rdata)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_ERROR: state_nx = start_i ? S_RST_WR : state;
      S_RST_WR, S_START_WR, S_READ:
        state_nx = done ? (err_kind != ERR_NONE ? S_ERROR : abort_i ? S_IDLE : bus_nx)
                 : (!issued && abort_i) ? S_IDLE : state;
      S_GATE:  state_nx = abort_i ? S_IDLE : gcnt == GATE_W'(1) ? S_READ : S_GATE;
      S_DONE:  state_nx = (continuous_i && !abort_i) ? S_RST_WR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    busy_o         = !(state == S_IDLE || state == S_ERROR);
    result_valid_o = state == S_DONE;
    error_o        = state == S_ERROR;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      issued       <= 1'b0;
      gate_len     <= '0;
      gcnt         <= '0;
      result_o     <= '0;
      meas_count_o <= '0;
      err_code_o   <= ERR_NONE;
    end else begin
      issued <= done ? 1'b0 : req ? 1'b1 : issued;
      if (accept) gate_len <= gate_cycles_i == '0 ? GATE_W'(1) : gate_cycles_i;
      gcnt <= state == S_GATE ? gcnt - GATE_W'(1) : gate_len;
      if (done && err_kind == ERR_NONE && state == S_READ) result_o <= rdata;
      if (state == S_DONE) meas_count_o <= meas_count_o + 16'd1;
      err_code_o <= (done && err_kind != ERR_NONE) ? err_kind : accept ? ERR_NONE : err_code_o;
    end
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// tb_freq_meas_sequencer: scoreboard bench with a scripted Wishbone slave for freq_meas_sequencer.
module tb_freq_meas_sequencer;
  logic clk = 1'b0, rst_i = 1'b0, start_i = 1'b0, continuous_i = 1'b0, abort_i = 1'b0;
  logic [23:0] gate_cycles_i = '0;
  logic busy_o, result_valid_o, error_o, m_we_o, m_cyc_o, m_stb_o;
  logic [31:0] result_o, m_adr_o, m_dat_o;
  logic [15:0] meas_count_o;
  logic [1:0] err_code_o;
  logic [3:0] m_sel_o;
  logic [31:0] m_dat_i = '0;
  logic m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [64:0] exp_bus[$];
  logic [31:0] exp_res[$];
  byte resp_q[$];
  byte cur = "A";
  int stb_hi = 0, vcount = 0, cyc_n = 0, t_sack = 0, t_rd = 0, chk_drop = 0;
  logic stb_prev = 1'b0;
  logic [31:0] rd_data = '0;
  always #5 clk = ~clk;
  freq_meas_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
    .abort_i(abort_i), .gate_cycles_i(gate_cycles_i), .busy_o(busy_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .meas_count_o(meas_count_o), .error_o(error_o),
    .err_code_o(err_code_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_sel_o(m_sel_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
  );
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction
  task automatic push_meas(input logic [31:0] r);
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h80));
    exp_bus.push_back(txn(1'b0, 32'h9, 32'h0));
    exp_res.push_back(r);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic go(input logic [23:0] g);
    @(negedge clk);
    gate_cycles_i = g;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask
  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy_o; i++) @(negedge clk);
    chk("idle_in_time", busy_o, 0);
  endtask
  always @(posedge clk) cyc_n++;
  // Slave: one scripted response per stb assertion (A ack, E err, R rty, S silent).
  always @(negedge clk) begin
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;
    if (chk_drop != 0) begin
      chk("stb_drop", m_stb_o, 0);
      if (chk_drop == 1) chk("cyc_drop", m_cyc_o, 0);
      chk_drop = 0;
    end
    if (m_stb_o) begin
      stb_hi++;
      if (!stb_prev) begin
        if (exp_bus.size() == 0) chk("stb_spare", exp_bus.size(), 1);
        else chk("bus_txn", {m_we_o, m_adr_o, m_dat_o}, exp_bus.pop_front());
        cur = "A";
        if (resp_q.size() != 0) cur = resp_q.pop_front();
        if (m_adr_o == 32'h9) t_rd = cyc_n;
      end
      m_dat_i = rd_data;
      if (cur == "A") begin
        m_ack_i = 1'b1;
        chk_drop = 1;
        if (m_adr_o == 32'h8 && m_dat_o == 32'h80) t_sack = cyc_n;
      end else if (cur == "E") begin
        m_err_i = 1'b1;
        chk_drop = 1;
      end else if (cur == "R") begin
        m_rty_i = 1'b1;
        chk_drop = 2;
      end
    end
    stb_prev = m_stb_o;
    if (result_valid_o) begin
      vcount++;
      if (exp_res.size() == 0) chk("valid_spare", exp_res.size(), 1);
      else chk("result", result_o, exp_res.pop_front());
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_outs", {busy_o, result_o, result_valid_o, meas_count_o, error_o, err_code_o, m_cyc_o, m_stb_o, m_we_o}, 0);
    chk("rst_bus", {m_adr_o, m_dat_o}, 0);
    rst_i = 1'b1;
    tick(2);
    chk("sel", m_sel_o, 4'hF);
    // reset in the middle of a stalled transaction
    resp_q.push_back("S");
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    go(10);
    for (int i = 0; i < 10 && !m_stb_o; i++) @(negedge clk);
    chk("t1_stb_seen", m_stb_o, 1);
    tick(2);
    #2 rst_i = 1'b0;
    #1 chk("rst_async_drop", {m_cyc_o, m_stb_o}, 0);
    @(negedge clk) rst_i = 1'b1;
    tick(1);
    chk("post_rst_outs", {busy_o, result_o, result_valid_o, meas_count_o, error_o, err_code_o, m_cyc_o, m_stb_o, m_we_o}, 0);
    chk("post_rst_bus", {m_adr_o, m_dat_o}, 0);
    // single shot, gate 100
    rd_data = 32'h19;
    push_meas(32'h19);
    go(100);
    wait_idle(400);
    chk("t2_result", result_o, 32'h19);
    chk("t2_count", meas_count_o, 1);
    chk("t2_err", {error_o, err_code_o}, 0);
    chk("t2_valids", vcount, 1);
    chk("t2_gate_wait", (t_rd - t_sack) >= 100, 1);
    // two retries on START then ack; gate 0 behaves as 1
    rd_data = 32'h55;
    resp_q = '{"A", "R", "R", "A", "A"};
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    repeat (3) exp_bus.push_back(txn(1'b1, 32'h8, 32'h80));
    exp_bus.push_back(txn(1'b0, 32'h9, 32'h0));
    exp_res.push_back(32'h55);
    go(0);
    wait_idle(200);
    chk("t3_err", error_o, 0);
    chk("t3_count", meas_count_o, 2);
    chk("t3_result", result_o, 32'h55);
    // four retries exhaust the budget
    resp_q = '{"A", "R", "R", "R", "R"};
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    repeat (4) exp_bus.push_back(txn(1'b1, 32'h8, 32'h80));
    go(5);
    wait_idle(200);
    chk("t3_retry_err", {error_o, err_code_o}, {1'b1, 2'd2});
    chk("t3_hold", result_o, 32'h55);
    // bus error on the read leaves result unchanged
    rd_data = 32'h66;
    resp_q = '{"A", "A", "E"};
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h80));
    exp_bus.push_back(txn(1'b0, 32'h9, 32'h0));
    go(3);
    wait_idle(100);
    chk("t4_bus_err", {error_o, err_code_o}, {1'b1, 2'd1});
    chk("t4_hold", result_o, 32'h55);
    chk("t4_count", meas_count_o, 2);
    rd_data = 32'h77;
    push_meas(32'h77);
    go(3);
    chk("t4_err_clr", {error_o, err_code_o}, 0);
    wait_idle(100);
    chk("t4_result", result_o, 32'h77);
    chk("t4_count2", meas_count_o, 3);
    // silent slave -> timeout after 16 stb cycles
    resp_q.push_back("S");
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    stb_hi = 0;
    go(3);
    wait_idle(60);
    chk("t5_timeout", {error_o, err_code_o}, {1'b1, 2'd3});
    chk("t5_cyc", m_cyc_o, 0);
    chk("t5_stb_cycles", stb_hi, 16);
    // continuous, abort during the third gate
    rd_data = 32'h100;
    continuous_i = 1'b1;
    push_meas(32'h100);
    push_meas(32'h100);
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h01));
    exp_bus.push_back(txn(1'b1, 32'h8, 32'h80));
    go(20);
    for (int i = 0; i < 400 && exp_bus.size() != 0; i++) @(negedge clk);
    chk("t6_third_start", exp_bus.size(), 0);
    tick(5);
    abort_i = 1'b1;
    wait_idle(20);
    tick(2);
    abort_i = 1'b0;
    continuous_i = 1'b0;
    tick(30);
    chk("t6_count", meas_count_o, 5);
    chk("t6_busy", busy_o, 0);
    chk("t6_err", error_o, 0);
    chk("bus_left", exp_bus.size(), 0);
    chk("res_left", exp_res.size(), 0);
    chk("valid_total", vcount, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
